spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// Command-driven SPI master: serializes a 10-bit opcode+payload word and, on read-data
// commands, waits RD_WAIT turnaround cycles before clocking eight MISO bits into rd_data.
//
// state | meaning
// IDLE  | SS_n high, waiting for start
// SETUP | SS_n low one cycle before the first command bit
// SHIFT | ten command bits on MOSI, MSB first
// WAIT  | slave turnaround before read data (read-data only)
// READ  | eight MISO samples, MSB first
// END   | SS_n high, done pulse
// GAP   | SS_n high for GAP_CYCLES before returning to IDLE
module spi_master #(
   parameter int GAP_CYCLES = 1,
   parameter int RD_WAIT    = 2
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] cmd,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_READ, S_END, S_GAP
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
   localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [9:0] cmd_q, cmd_nxt;
   logic [7:0] shreg;
   logic       ss_nxt, mosi_nxt, busy_nxt, done_nxt;

   // Outputs are computed from the next state so SS_n/MOSI leave flops aligned with the state.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         cmd_q   <= 10'd0;
         shreg   <= 8'd0;
         rd_data <= 8'd0;
         SS_n    <= 1'b1;
         MOSI    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cmd_q <= cmd_nxt;
         SS_n  <= ss_nxt;
         MOSI  <= mosi_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         if (state == S_READ) begin
            shreg <= {shreg[6:0], MISO};
         end
         if (state == S_READ && state_nxt == S_END) begin
            rd_data <= {shreg[6:0], MISO};
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cmd_nxt   = cmd_q;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_SETUP;
               cmd_nxt   = cmd;
               cnt_nxt   = 4'd0;
            end
         end
         S_SETUP: begin
            state_nxt = S_SHIFT;
            cnt_nxt   = 4'd9;
         end
         S_SHIFT: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else if (cmd_q[9:8] == 2'b11) begin
               if (RD_WAIT > 0) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end else begin
                  state_nxt = S_READ;
                  cnt_nxt   = 4'd7;
               end
            end else begin
               state_nxt = S_END;
            end
         end
         S_WAIT: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               state_nxt = S_READ;
               cnt_nxt   = 4'd7;
            end
         end
         S_READ: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               state_nxt = S_END;
            end
         end
         S_END: begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LOAD;
         end
         S_GAP: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      ss_nxt   = 1'b1;
      mosi_nxt = 1'b0;
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_END);
      case (state_nxt)
         S_SETUP, S_SHIFT, S_WAIT, S_READ: ss_nxt = 1'b0;
         default: ss_nxt = 1'b1;
      endcase
      if (state_nxt == S_SHIFT) begin
         mosi_nxt = cmd_nxt[cnt_nxt];
      end
   end

endmodule
